// File: rtl/fwd_tracker.sv
// Operand forwarding tracker: records in-flight destination registers and their
// Tnew countdown, forwards ready results to decode and raises the load-use stall.
module fwd_tracker #(
   parameter int unsigned DEPTH = 3,
   parameter int unsigned NRD   = 2,
   parameter int unsigned DW    = 32,
   parameter int unsigned AW    = 5,
   parameter int unsigned TW    = 3
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         issue_valid,
   input  logic [AW-1:0]                issue_addr,
   input  logic [TW-1:0]                issue_tnew,
   input  logic [DW-1:0]                issue_data,
   input  logic [DEPTH-1:0]             res_valid,
   input  logic [DEPTH*DW-1:0]          res_data,
   input  logic [NRD*AW-1:0]            rd_addr,
   input  logic [NRD*TW-1:0]            rd_tuse,
   input  logic [NRD*DW-1:0]            rf_data,
   input  logic                         freeze,
   input  logic                         flush,
   output logic [NRD*DW-1:0]            rd_data,
   output logic [NRD-1:0]               rd_fwd,
   output logic                         stall,
   output logic [$clog2(DEPTH+1)-1:0]   inflight
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] ent_valid;
   logic [AW-1:0]    ent_addr [DEPTH];
   logic [TW-1:0]    ent_tnew [DEPTH];
   logic [DW-1:0]    ent_data [DEPTH];

   logic [DEPTH-1:0] nxt_valid;
   logic [AW-1:0]    nxt_addr [DEPTH];
   logic [TW-1:0]    nxt_tnew [DEPTH];
   logic [DW-1:0]    nxt_data [DEPTH];
   logic [CW-1:0]    nxt_cnt;

   logic             hazard;
   logic             hit;
   logic [TW-1:0]    win_tnew;
   logic [DW-1:0]    win_data;
   logic [AW-1:0]    port_addr;

   // The writeback stage's result has nowhere further to travel.
   logic unused_res;
   assign unused_res = ^{res_valid[DEPTH-1], res_data[(DEPTH-1)*DW +: DW]};

   // Per-port match: the youngest (lowest index) valid entry wins.
   always_comb begin
      hazard    = 1'b0;
      rd_fwd    = '0;
      rd_data   = rf_data;
      hit       = 1'b0;
      win_tnew  = '0;
      win_data  = '0;
      port_addr = '0;
      for (int unsigned p = 0; p < NRD; p++) begin
         hit       = 1'b0;
         win_tnew  = '0;
         win_data  = '0;
         port_addr = rd_addr[p*AW +: AW];
         for (int unsigned k = 0; k < DEPTH; k++) begin
            if (!hit && ent_valid[k] && (ent_addr[k] == port_addr) && (port_addr != '0)) begin
               hit      = 1'b1;
               win_tnew = ent_tnew[k];
               win_data = ent_data[k];
            end
         end
         if (hit && (win_tnew == '0)) begin
            rd_fwd[p]             = 1'b1;
            rd_data[p*DW +: DW]   = win_data;
         end
         if (hit && (win_tnew > rd_tuse[p*TW +: TW])) begin
            hazard = 1'b1;
         end
      end
   end

   assign stall = (freeze & ~flush) | (issue_valid & hazard);

   // Pipeline advance / hold / flush and the next occupancy count.
   always_comb begin
      nxt_valid = ent_valid;
      nxt_addr  = ent_addr;
      nxt_tnew  = ent_tnew;
      nxt_data  = ent_data;
      nxt_cnt   = '0;
      if (flush) begin
         nxt_valid = '0;
      end else if (!freeze) begin
         for (int unsigned k = 1; k < DEPTH; k++) begin
            nxt_valid[k] = ent_valid[k-1];
            nxt_addr[k]  = ent_addr[k-1];
            nxt_tnew[k]  = (ent_tnew[k-1] == '0) ? '0 : ent_tnew[k-1] - TW'(1);
            nxt_data[k]  = res_valid[k-1] ? res_data[(k-1)*DW +: DW] : ent_data[k-1];
         end
         nxt_valid[0] = issue_valid & ~stall & (issue_addr != '0);
         nxt_addr[0]  = issue_addr;
         nxt_tnew[0]  = issue_tnew;
         nxt_data[0]  = issue_data;
      end
      for (int unsigned k = 0; k < DEPTH; k++) begin
         nxt_cnt = nxt_cnt + CW'(nxt_valid[k]);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ent_valid <= '0;
         inflight  <= '0;
      end else begin
         ent_valid <= nxt_valid;
         ent_addr  <= nxt_addr;
         ent_tnew  <= nxt_tnew;
         ent_data  <= nxt_data;
         inflight  <= nxt_cnt;
      end
   end

endmodule

// File: tb/tb_fwd_tracker.sv
// Table-driven bench for fwd_tracker: each vector drives one cycle and queues its
// expected outputs; a negedge checker pops and compares them.
module tb_fwd_tracker;

   logic         clk;
   logic         reset;
   logic         issue_valid;
   logic [4:0]   issue_addr;
   logic [2:0]   issue_tnew;
   logic [31:0]  issue_data;
   logic [2:0]   res_valid;
   logic [95:0]  res_data;
   logic [9:0]   rd_addr;
   logic [5:0]   rd_tuse;
   logic [63:0]  rf_data;
   logic         freeze;
   logic         flush;
   logic [63:0]  rd_data;
   logic [1:0]   rd_fwd;
   logic         stall;
   logic [1:0]   inflight;

   fwd_tracker dut (
      .clk(clk), .reset(reset),
      .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_tnew(issue_tnew),
      .issue_data(issue_data), .res_valid(res_valid), .res_data(res_data),
      .rd_addr(rd_addr), .rd_tuse(rd_tuse), .rf_data(rf_data),
      .freeze(freeze), .flush(flush),
      .rd_data(rd_data), .rd_fwd(rd_fwd), .stall(stall), .inflight(inflight)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n;
      logic        iv;
      logic [4:0]  ia;
      logic [2:0]  itn;
      logic [31:0] idata;
      logic [2:0]  rv;
      logic [31:0] rdat;
      logic [4:0]  ra0;
      logic [2:0]  tu0;
      logic [4:0]  ra1;
      logic [2:0]  tu1;
      logic        frz;
      logic        fl;
      logic        e_stall;
      logic        e_f0;
      logic [31:0] e_d0;
      logic        e_f1;
      logic [31:0] e_d1;
      logic [1:0]  e_inf;
   } vec_t;

   typedef struct {
      int          idx;
      logic        stall;
      logic [1:0]  fwd;
      logic [31:0] d0;
      logic [31:0] d1;
      logic [1:0]  inf;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   function automatic void add(
      int unsigned rst_n, int unsigned iv, int unsigned ia, int unsigned itn, int unsigned idata,
      int unsigned rv, int unsigned rdat, int unsigned ra0, int unsigned tu0,
      int unsigned ra1, int unsigned tu1, int unsigned frz, int unsigned fl,
      int unsigned e_stall, int unsigned e_f0, int unsigned e_d0,
      int unsigned e_f1, int unsigned e_d1, int unsigned e_inf);
      vec_t v;
      v.rst_n = 1'(rst_n); v.iv = 1'(iv); v.ia = 5'(ia); v.itn = 3'(itn); v.idata = idata;
      v.rv = 3'(rv); v.rdat = rdat; v.ra0 = 5'(ra0); v.tu0 = 3'(tu0);
      v.ra1 = 5'(ra1); v.tu1 = 3'(tu1); v.frz = 1'(frz); v.fl = 1'(fl);
      v.e_stall = 1'(e_stall); v.e_f0 = 1'(e_f0); v.e_d0 = e_d0;
      v.e_f1 = 1'(e_f1); v.e_d1 = e_d1; v.e_inf = 2'(e_inf);
      tbl.push_back(v);
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   // Outputs are sampled on the falling edge, mid-cycle after the vector is applied.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("stall",    e.idx, 32'(stall),         32'(e.stall));
         chk("rd_fwd",   e.idx, 32'(rd_fwd),        32'(e.fwd));
         chk("rd_data0", e.idx, rd_data[31:0],      e.d0);
         chk("rd_data1", e.idx, rd_data[63:32],     e.d1);
         chk("inflight", e.idx, 32'(inflight),      32'(e.inf));
      end
   end

   initial begin
      reset = 1'b0; issue_valid = 1'b0; issue_addr = '0; issue_tnew = '0; issue_data = '0;
      res_valid = '0; res_data = '0; rd_addr = '0; rd_tuse = '0; rf_data = '0;
      freeze = 1'b0; flush = 1'b0;

      //   rst iv ia  tn idata     rv rdat     ra0 tu0 ra1 tu1 frz fl  st f0 d0       f1 d1      inf
      // idle after reset, then zero-latency link value for r31
      add(1, 0, 0,  0, 0,        0, 0,       5,  0,  0,  0,  0,  0,  0, 0, 0,       0, 0,       0);
      add(1, 1, 31, 0, 'h3008,   0, 0,       31, 0,  0,  0,  0,  0,  0, 0, 0,       0, 0,       0);
      add(1, 0, 0,  0, 0,        0, 0,       31, 0,  31, 0,  0,  0,  0, 1, 'h3008,  1, 'h3008,  1);
      add(1, 0, 0,  0, 0,        0, 0,       31, 0,  0,  0,  0,  0,  0, 1, 'h3008,  0, 0,       1);
      add(1, 0, 0,  0, 0,        0, 0,       31, 0,  0,  0,  0,  0,  0, 1, 'h3008,  0, 0,       1);
      add(1, 0, 0,  0, 0,        0, 0,       31, 0,  0,  0,  0,  0,  0, 0, 0,       0, 0,       0);
      // load-use on r8, result captured from stage 1
      add(1, 1, 8,  2, 'hDEAD,   0, 0,       0,  0,  0,  0,  0,  0,  0, 0, 0,       0, 0,       0);
      add(1, 1, 0,  0, 0,        0, 0,       8,  0,  8,  2,  0,  0,  1, 0, 0,       0, 0,       1);
      add(1, 1, 0,  0, 0,        2, 'h1000,  8,  0,  8,  1,  0,  0,  1, 0, 0,       0, 0,       1);
      add(1, 1, 0,  0, 0,        0, 0,       8,  0,  0,  0,  0,  0,  0, 1, 'h1001,  0, 0,       1);
      // youngest match wins; tnew==tuse does not stall; stall gated by issue_valid
      add(1, 1, 5,  0, 'h22,     0, 0,       0,  0,  0,  0,  0,  0,  0, 0, 0,       0, 0,       0);
      add(1, 1, 7,  3, 'h77,     0, 0,       5,  0,  0,  0,  0,  0,  0, 1, 'h22,    0, 0,       1);
      add(1, 1, 5,  0, 'h11,     0, 0,       5,  0,  7,  3,  0,  0,  0, 1, 'h22,    0, 0,       2);
      add(1, 0, 0,  0, 0,        0, 0,       5,  0,  7,  0,  0,  0,  0, 1, 'h11,    0, 0,       3);
      // register 0 is never tracked
      add(1, 1, 0,  1, 'h999,    0, 0,       0,  0,  5,  0,  0,  0,  0, 0, 0,       1, 'h11,    2);
      add(1, 0, 0,  0, 0,        0, 0,       5,  0,  7,  0,  0,  0,  0, 1, 'h11,    0, 0,       1);
      // fill three entries, freeze, then resume with a stage-0 result
      add(1, 1, 1,  2, 'h101,    0, 0,       0,  0,  0,  0,  0,  0,  0, 0, 0,       0, 0,       0);
      add(1, 1, 2,  0, 'h202,    0, 0,       0,  0,  0,  0,  0,  0,  0, 0, 0,       0, 0,       1);
      add(1, 1, 3,  1, 'h303,    0, 0,       0,  0,  0,  0,  0,  0,  0, 0, 0,       0, 0,       2);
      add(1, 1, 4,  0, 'h404,    7, 'h5000,  3,  1,  1,  0,  1,  0,  1, 0, 0,       1, 'h101,   3);
      add(1, 0, 0,  0, 0,        1, 'h6000,  2,  0,  3,  0,  0,  0,  0, 1, 'h202,   0, 0,       3);
      add(1, 1, 9,  1, 'h909,    0, 0,       3,  0,  2,  0,  0,  0,  0, 1, 'h6000,  1, 'h202,   2);
      add(1, 1, 10, 0, 'hA0A,    0, 0,       0,  0,  0,  0,  0,  0,  0, 0, 0,       0, 0,       2);
      add(1, 1, 11, 0, 'hB0B,    0, 0,       9,  0,  0,  0,  0,  0,  0, 1, 'h909,   0, 0,       2);
      // flush beats freeze and issue
      add(1, 1, 12, 0, 'hC0C,    0, 0,       11, 0,  0,  0,  1,  1,  0, 1, 'hB0B,   0, 0,       3);
      add(1, 0, 0,  0, 0,        0, 0,       11, 0,  9,  0,  0,  0,  0, 0, 0,       0, 0,       0);
      // synchronous reset mid-operation
      add(1, 1, 20, 0, 'h2020,   0, 0,       0,  0,  0,  0,  0,  0,  0, 0, 0,       0, 0,       0);
      add(1, 1, 21, 0, 'h2121,   0, 0,       0,  0,  0,  0,  0,  0,  0, 0, 0,       0, 0,       1);
      add(1, 1, 22, 0, 'h2222,   0, 0,       0,  0,  0,  0,  0,  0,  0, 0, 0,       0, 0,       2);
      add(0, 1, 23, 0, 'h2323,   0, 0,       22, 0,  0,  0,  0,  0,  0, 1, 'h2222,  0, 0,       3);
      add(1, 0, 0,  0, 0,        0, 0,       22, 0,  20, 0,  0,  0,  0, 0, 0,       0, 0,       0);
      // freeze must not decrement tnew
      add(1, 1, 6,  2, 'h66,     0, 0,       0,  0,  0,  0,  0,  0,  0, 0, 0,       0, 0,       0);
      add(1, 1, 0,  0, 0,        0, 0,       6,  0,  0,  0,  1,  0,  1, 0, 0,       0, 0,       1);
      add(1, 1, 0,  0, 0,        0, 0,       6,  0,  0,  0,  1,  0,  1, 0, 0,       0, 0,       1);
      add(1, 1, 0,  0, 0,        0, 0,       6,  0,  0,  0,  0,  0,  1, 0, 0,       0, 0,       1);
      add(1, 1, 0,  0, 0,        0, 0,       6,  0,  0,  0,  0,  0,  1, 0, 0,       0, 0,       1);
      add(1, 1, 0,  0, 0,        0, 0,       6,  0,  0,  0,  0,  0,  0, 1, 'h66,    0, 0,       1);

      repeat (2) @(posedge clk);

      for (int i = 0; i < tbl.size(); i++) begin
         vec_t v;
         exp_t e;
         logic [31:0] rf0;
         logic [31:0] rf1;
         v = tbl[i];
         rf0 = 32'hA000_0000 + 32'(i);
         rf1 = 32'hB000_0000 + 32'(i);
         @(posedge clk);
         #1;
         reset       = v.rst_n;
         issue_valid = v.iv;
         issue_addr  = v.ia;
         issue_tnew  = v.itn;
         issue_data  = v.idata;
         res_valid   = v.rv;
         res_data    = {v.rdat + 32'd2, v.rdat + 32'd1, v.rdat};
         rd_addr     = {v.ra1, v.ra0};
         rd_tuse     = {v.tu1, v.tu0};
         rf_data     = {rf1, rf0};
         freeze      = v.frz;
         flush       = v.fl;
         e.idx   = i;
         e.stall = v.e_stall;
         e.fwd   = {v.e_f1, v.e_f0};
         e.d0    = v.e_f0 ? v.e_d0 : rf0;
         e.d1    = v.e_f1 ? v.e_d1 : rf1;
         e.inf   = v.e_inf;
         sb.push_back(e);
      end

      for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
      n_chk++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
